seg_scan_controller: RTL

- Time-multiplexes one shared BCD-to-7-segment decoder across NUM_DIGITS common-anode digits.
- Holds the displayed value, sequences digit select with inter-digit blanking to prevent ghosting, and suppresses leading zeros.
- New values arrive through a load/ready handshake and are committed only at frame boundaries, so a frame never shows digits from two different values.
- Sits between the lab datapath (value producer) and the decoder/anode pins.

---
 rtl/seg_scan_controller.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/seg_scan_controller.sv
// seg_scan_controller
// Drives NUM_DIGITS common-anode digits through one shared BCD-to-7-segment
// decoder. Each digit gets a slot of REFRESH_DIV cycles. The first
// BLANK_CYCLES of every slot keep all anodes off so the previous digit's
// segments cannot ghost onto the next one. A value offered on the load/ready
// handshake is parked in a pending register and only becomes visible at a
// frame boundary, so one frame never mixes two values.
module seg_scan_controller #(
   parameter int NUM_DIGITS    = 4,
   parameter int REFRESH_DIV   = 50000,
   parameter int BLANK_CYCLES  = 500,
   parameter bit BLANK_LEADING = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   output logic                    ready,
   output logic [3:0]              digit_bcd,
   output logic [NUM_DIGITS-1:0]   anode_n
);

   localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = $clog2(NUM_DIGITS);

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [3:0]       BCD_BLANK = 4'hF;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } state_t;

   // Slot timing
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             slot_wrap;
   logic             frame_wrap;

   // Value path and handshake
   logic [4*NUM_DIGITS-1:0] shown_q, shown_d;
   logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
   logic                    pending_valid_q, pending_valid_d;
   logic                    ready_q, ready_d;
   logic                    transfer;
   logic                    commit;

   // Leading-zero suppression
   logic [NUM_DIGITS-1:0] suppress;
   logic                  run_zero;

   // Scan FSM and registered pin drivers
   state_t                state_q, state_d;
   logic [NUM_DIGITS-1:0] anode_n_q, anode_n_d;
   logic [3:0]            digit_bcd_q, digit_bcd_d;

   assign slot_wrap  = (cnt_q == CNT_LAST);
   assign frame_wrap = slot_wrap && (idx_q == IDX_LAST);
   // ready_q is only ever high while the pending register is empty, so a
   // transfer can never collide with a commit (which needs it full).
   assign transfer   = load && ready_q;
   assign commit     = frame_wrap && pending_valid_q;

   // Slot counter and digit index; the index wrap is the frame boundary.
   always_comb begin
      // NOTE: every signal gets a default first, so no branch can leave it
      // unassigned and infer a latch.
      cnt_d = cnt_q + CNT_W'(1);
      idx_d = idx_q;
      if (slot_wrap) begin
         cnt_d = '0;
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end
   end

   // Capture offered values into pending; promote pending to shown at frame boundaries.
   always_comb begin
      shown_d         = shown_q;
      pending_d       = pending_q;
      pending_valid_d = pending_valid_q;
      if (commit) begin
         shown_d         = pending_q;
         pending_valid_d = 1'b0;
      end
      if (transfer) begin
         pending_d       = value;
         pending_valid_d = 1'b1;
      end
      // ready drops on the capture edge but rises one cycle after a commit.
      ready_d = !pending_valid_d && !commit;
   end

   // Mark digits above the most significant nonzero nibble as blank; digit 0 always shows.
   always_comb begin
      suppress = '0;
      run_zero = 1'b1;
      // NOTE: blocking assignments are correct here: run_zero is a
      // combinational running AND that each iteration must see updated.
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         run_zero    = run_zero && (shown_d[4*i +: 4] == 4'h0);
         suppress[i] = BLANK_LEADING && run_zero;
      end
   end

   // Next scan state and the pin values that go with it.
   always_comb begin
      state_d     = state_q;
      anode_n_d   = '1;
      digit_bcd_d = BCD_BLANK;
      unique case (state_q)
         ST_BLANK: if (cnt_d == CNT_BLANK) state_d = ST_DRIVE;
         ST_DRIVE: if (slot_wrap)          state_d = ST_BLANK;
         default:                          state_d = ST_BLANK;
      endcase
      if (state_d == ST_DRIVE) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
               anode_n_d[i] = 1'b0;
               digit_bcd_d  = suppress[i] ? BCD_BLANK : shown_d[4*i +: 4];
            end
         end
      end
   end

   // Scan state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_BLANK;
      end else begin
         state_q <= state_d;
      end
   end

   // Counters, value registers, handshake and registered pin drivers.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      // The shown/pending registers are plain flops, reset like the rest, so
      // a reset mid-operation discards any pending value.
      if (!rst_n) begin
         cnt_q           <= '0;
         idx_q           <= '0;
         shown_q         <= '0;
         pending_q       <= '0;
         pending_valid_q <= 1'b0;
         ready_q         <= 1'b1;
         anode_n_q       <= '1;
         digit_bcd_q     <= BCD_BLANK;
      end else begin
         cnt_q           <= cnt_d;
         idx_q           <= idx_d;
         shown_q         <= shown_d;
         pending_q       <= pending_d;
         pending_valid_q <= pending_valid_d;
         ready_q         <= ready_d;
         anode_n_q       <= anode_n_d;
         digit_bcd_q     <= digit_bcd_d;
      end
   end

   assign ready     = ready_q;
   assign digit_bcd = digit_bcd_q;
   assign anode_n   = anode_n_q;

endmodule
